// File: rtl/code_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_map_pkg
//  Description : Shared definitions for the code-mapper sweep engine.
//                - Code widths.
//                - Golden 4-bit -> 3-bit map.
//                - Sweep FSM state encoding.
//                - Error counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package code_map_pkg;

    localparam int CODE_IN_W  = 4;
    localparam int CODE_OUT_W = 3;
    localparam int N_CODES    = 16;
    localparam int ERR_CNT_W  = 5;   // must hold 0..N_CODES inclusive

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Golden response of the mapper, indexed by input code.
    localparam logic [CODE_OUT_W-1:0] EXP_MAP [0:N_CODES-1] = '{
        3'd4, 3'd2, 3'd5, 3'd2, 3'd1, 3'd7, 3'd2, 3'd5,
        3'd2, 3'd5, 3'd3, 3'd5, 3'd3, 3'd5, 3'd2, 3'd5
    };

endpackage
`default_nettype wire

// File: rtl/code_sweep_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : code_sweep_driver_if
//  Description : Control / mapper / result bundle of the sweep engine.
//                master : the sweep engine (drives drv_i and results)
//                slave  : host plus mapper (drives start and dut_o)
//  Signals     : start, drv_i[3:0], dut_o[2:0], busy, done, pass,
//                err_count[4:0], first_err_idx[3:0], first_err_got[2:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface code_sweep_driver_if;
    import code_map_pkg::*;

    logic                  start;
    logic [CODE_IN_W-1:0]  drv_i;
    logic [CODE_OUT_W-1:0] dut_o;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [CODE_IN_W-1:0]  first_err_idx;
    logic [CODE_OUT_W-1:0] first_err_got;

    modport master (
        input  start, dut_o,
        output drv_i, busy, done, pass, err_count, first_err_idx, first_err_got
    );

    modport slave (
        output start, dut_o,
        input  drv_i, busy, done, pass, err_count, first_err_idx, first_err_got
    );

endinterface
`default_nettype wire

// File: rtl/code_map_rom.sv
`default_nettype none
// ============================================================================
//  Module      : code_map_rom
//  Description : Combinational lookup of the golden mapper response.
//  Ports       : i_idx  [3:0]  input code
//                o_code [2:0]  expected mapper output for i_idx
//  Revision    : 1.0  initial release
// ============================================================================
module code_map_rom
    import code_map_pkg::*;
(
    input  wire logic [CODE_IN_W-1:0]  i_idx,
    output logic      [CODE_OUT_W-1:0] o_code
);

    assign o_code = EXP_MAP[i_idx];

endmodule
`default_nettype wire

// File: rtl/code_sweep_driver.sv
`default_nettype none
// ============================================================================
//  Module      : code_sweep_driver
//  Description : Sweeps all 16 input codes into the code mapper.
//                - Holds each code for SETTLE_CYCLES cycles.
//                - Then samples the mapper output and checks it against
//                  the golden map.
//                - Reports mismatch count, first failing code and pass/fail.
//  Ports       : clk, rst (sync, active high)
//                bus.master : start, drv_i, dut_o, busy, done, pass,
//                             err_count, first_err_idx, first_err_got
//  Config      : SWEEP_STOP_ON_ERR_EN - when defined, the first mismatch
//                ends the sweep with drv_i left on the failing code.
//  Revision    : 1.0  initial release
// ============================================================================
module code_sweep_driver
    import code_map_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,    // 1..15
    parameter int N_CODES       = 16
)(
    input  wire logic            clk,
    input  wire logic            rst,
    code_sweep_driver_if.master  bus
);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_SETTLE = ST_SETTLE;
    localparam logic [1:0] c_ST_SAMPLE = ST_SAMPLE;
    localparam logic [1:0] c_ST_DONE   = ST_DONE;

    localparam logic [CODE_IN_W-1:0] c_LAST_IDX    = CODE_IN_W'(N_CODES - 1);
    localparam logic [3:0]           c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX     = ERR_CNT_W'(N_CODES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [CODE_IN_W-1:0]  r_idx;
    logic [ERR_CNT_W-1:0]  r_err;
    logic [CODE_IN_W-1:0]  r_fidx;
    logic [CODE_OUT_W-1:0] r_fgot;

    logic [CODE_OUT_W-1:0] w_exp;
    logic                  w_mismatch;
    logic                  w_stop;

    code_map_rom u_rom (
        .i_idx  (r_idx),
        .o_code (w_exp)
    );

    assign w_mismatch = (bus.dut_o != w_exp);

`ifdef SWEEP_STOP_ON_ERR_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_fidx  <= '0;
            r_fgot  <= '0;
        end else begin
            case (r_state)
                // A start from DONE behaves exactly like one from IDLE.
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_state <= c_ST_SETTLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_err   <= '0;
                        r_fidx  <= '0;
                        r_fgot  <= '0;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= c_ST_SAMPLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_ST_SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err != c_ERR_MAX) begin
                            r_err <= r_err + ERR_CNT_W'(1);
                        end
                        // Capture only on the first mismatch of the sweep.
                        if (r_err == '0) begin
                            r_fidx <= r_idx;
                            r_fgot <= bus.dut_o;
                        end
                    end
                    // The index is left in place on exit so drv_i keeps the
                    // last (or failing) code during DONE.
                    if (w_stop || (r_idx == c_LAST_IDX)) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx   <= r_idx + CODE_IN_W'(1);
                        r_cnt   <= '0;
                        r_state <= c_ST_SETTLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // All outputs decode straight from registers.
    assign bus.drv_i         = r_idx;
    assign bus.busy          = (r_state == c_ST_SETTLE) || (r_state == c_ST_SAMPLE);
    assign bus.done          = (r_state == c_ST_DONE);
    assign bus.pass          = (r_state == c_ST_DONE) && (r_err == '0);
    assign bus.err_count     = r_err;
    assign bus.first_err_idx = r_fidx;
    assign bus.first_err_got = r_fgot;

endmodule
`default_nettype wire

// File: tb/tb_code_sweep_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_sweep_driver
//  Description : Scoreboard bench for code_sweep_driver.
//                - A mapper model with selectable faults drives dut_o.
//                - Each started sweep pushes its hand-computed result.
//                - A monitor pops and compares on every rising done.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_code_sweep_driver;

    typedef struct {
        int err;
        int pass;
        int fidx;
        int fgot;
        int drv;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   mode;          // 0 golden, 1 code5->0, 2 stuck at 2, 3 code2->0
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   start_mark = 0;
    logic prev_done  = 1'b0;
    exp_t sb_q[$];

    // Hand-entered copy of the golden map for the mapper model.
    logic [2:0] tb_map [16] = '{3'd4, 3'd2, 3'd5, 3'd2, 3'd1, 3'd7, 3'd2, 3'd5,
                                3'd2, 3'd5, 3'd3, 3'd5, 3'd3, 3'd5, 3'd2, 3'd5};

    code_sweep_driver_if bus ();

    code_sweep_driver #(
        .SETTLE_CYCLES (1),
        .N_CODES       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mapper model with fault injection.
    always_comb begin
        bus.dut_o = tb_map[bus.drv_i];
        case (mode)
            1: if (bus.drv_i == 4'd5) bus.dut_o = 3'd0;
            2: bus.dut_o = 3'b010;
            3: if (bus.drv_i == 4'd2) bus.dut_o = 3'd0;
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each completed sweep against the oldest expectation.
    always @(negedge clk) begin
        if (bus.done && !prev_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_err_count", int'(bus.err_count), e.err);
                check("sb_pass", int'(bus.pass), e.pass);
                check("sb_first_err_idx", int'(bus.first_err_idx), e.fidx);
                check("sb_first_err_got", int'(bus.first_err_got), e.fgot);
                check("sb_drv_i_done", int'(bus.drv_i), e.drv);
                check("sb_latency", cyc - start_mark, e.lat);
                check("sb_busy_at_done", int'(bus.busy), 0);
            end
        end
        prev_done = bus.done;
    end

    task automatic pulse_start(input exp_t e, input bit push);
        bus.start  = 1'b1;
        start_mark = cyc;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_drv_i"}, int'(bus.drv_i), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_pass"}, int'(bus.pass), 0);
        check({tag, "_err_count"}, int'(bus.err_count), 0);
        check({tag, "_first_err_idx"}, int'(bus.first_err_idx), 0);
        check({tag, "_first_err_got"}, int'(bus.first_err_got), 0);
    endtask

    function automatic exp_t mk(input int err, input int pass, input int fidx,
                                input int fgot, input int drv, input int lat);
        exp_t e;
        e.err = err; e.pass = pass; e.fidx = fidx;
        e.fgot = fgot; e.drv = drv; e.lat = lat;
        return e;
    endfunction

    initial begin
        exp_t e_golden, e_f5, e_stuck, e_f2;
        int   stuck_errs;
        int   first_bad;

        // Mismatch count for the stuck-at-2 mapper, from the hand table.
        stuck_errs = 0;
        first_bad  = -1;
        for (int i = 0; i < 16; i++) begin
            if (tb_map[i] != 3'b010) begin
                stuck_errs++;
                if (first_bad < 0) first_bad = i;
            end
        end

        e_golden = mk(0, 1, 0, 0, 15, 33);
`ifdef SWEEP_STOP_ON_ERR_EN
        e_f5    = mk(1, 0, 5, 0, 5, 13);
        e_stuck = mk(1, 0, 0, 2, 0, 3);
        e_f2    = mk(1, 0, 2, 0, 2, 7);
`else
        e_f5    = mk(1, 0, 5, 0, 15, 33);
        e_stuck = mk(11, 0, 0, 2, 15, 33);
        e_f2    = mk(1, 0, 2, 0, 15, 33);
`endif

        rst       = 1'b1;
        bus.start = 1'b0;
        mode      = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Golden sweep with drv_i trace: each code held two cycles.
        pulse_start(e_golden, 1'b1);
        for (int n = 1; n <= 32; n++) begin
            check("trace_drv_i", int'(bus.drv_i), (n - 1) / 2);
            check("trace_busy", int'(bus.busy), 1);
            @(negedge clk);
        end
        wait_done("golden");

        mode = 1;
        pulse_start(e_f5, 1'b1);
        wait_done("fault_code5");

        mode = 2;
        check("stuck_count_table", stuck_errs, 11);
        check("stuck_first_table", first_bad, 0);
        pulse_start(e_stuck, 1'b1);
        wait_done("stuck_at_2");

        // Reset mid-sweep at cycle 12.
        mode = 0;
        pulse_start(e_golden, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("abort");
        rst = 1'b0;
        @(negedge clk);
        pulse_start(e_golden, 1'b1);
        wait_done("after_abort");

        // start re-pulsed at cycle 7 of a sweep is ignored.
        mode = 2;
        pulse_start(e_stuck, 1'b1);
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("repulse");

        // start in DONE clears results on the next edge.
        check("done_before_restart", int'(bus.done), 1);
        mode = 3;
        pulse_start(e_f2, 1'b1);
        check("restart_done_low", int'(bus.done), 0);
        check("restart_err_cleared", int'(bus.err_count), 0);
        check("restart_fidx_cleared", int'(bus.first_err_idx), 0);
        check("restart_fgot_cleared", int'(bus.first_err_got), 0);
        check("restart_busy", int'(bus.busy), 1);
        wait_done("fault_code2");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
